// File: rtl/sound_pkg.sv
// Shared tone codes, state encoding and event priority encoder
// for the sound sequencer and sound controller.
package sound_pkg;

    localparam logic [2:0] CODE_PING = 3'b010;
    localparam logic [2:0] CODE_PONG = 3'b001;
    localparam logic [2:0] CODE_GO   = 3'b011;
    localparam logic [2:0] CODE_STOP = 3'b000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Enum value doubles as priority rank: higher wins.
    typedef enum logic [1:0] {
        T_PONG = 2'd0,
        T_PING = 2'd1,
        T_GO   = 2'd2,
        T_STOP = 2'd3
    } tone_t;

    typedef struct packed {
        logic  vld;
        tone_t tone;
    } slot_t;

    function automatic slot_t prio_enc(
        input logic stop,
        input logic go,
        input logic ping,
        input logic pong
    );
        slot_t s;
        s.vld  = stop | go | ping | pong;
        s.tone = T_PONG;
        unique case (1'b1)
            stop:    s.tone = T_STOP;
            go:      s.tone = T_GO;
            ping:    s.tone = T_PING;
            default: s.tone = T_PONG;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] tone_code(input tone_t t);
        logic [2:0] c;
        unique case (t)
            T_PING:  c = CODE_PING;
            T_PONG:  c = CODE_PONG;
            T_GO:    c = CODE_GO;
            default: c = CODE_STOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Event inputs and tone outputs of the sound sequencer.
// Master drives events; slave is the sequencer.
interface sound_sequencer_if;

    logic       sound_en;
    logic       ev_ping;
    logic       ev_pong;
    logic       ev_go;
    logic       ev_stop;
    logic [2:0] code_sound;
    logic       mute;
    logic       busy;
    logic [7:0] drop_cnt;

    modport master (
        output sound_en, ev_ping, ev_pong, ev_go, ev_stop,
        input  code_sound, mute, busy, drop_cnt
    );

    modport slave (
        input  sound_en, ev_ping, ev_pong, ev_go, ev_stop,
        output code_sound, mute, busy, drop_cnt
    );

endinterface

// File: rtl/sound_event_arbiter.sv
// Picks the highest-priority event of a cycle and counts
// the simultaneous losers.
module sound_event_arbiter
    import sound_pkg::*;
(
    input  logic       en,
    input  logic       ev_ping,
    input  logic       ev_pong,
    input  logic       ev_go,
    input  logic       ev_stop,
    output slot_t      acc,
    output logic [1:0] n_lose
);

    logic [2:0] hits;

    // Winner plus loser count; nothing at all while disabled.
    always_comb begin
        acc    = '0;
        n_lose = 2'd0;
        hits   = {2'b0, ev_ping} + {2'b0, ev_pong}
               + {2'b0, ev_go} + {2'b0, ev_stop};
        if (en) begin
            acc = prio_enc(ev_stop, ev_go, ev_ping, ev_pong);
            if (hits != 3'd0)
                n_lose = 2'(hits - 3'd1);
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Tone sequencer: plays game-event tones with a fixed silent
// gap, one pending slot, stop preemption and a drop counter.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int CNT_W    = 24,
    parameter int DUR_PING = 1_250_000,
    parameter int DUR_PONG = 1_250_000,
    parameter int DUR_GO   = 5_000_000,
    parameter int DUR_STOP = 10_000_000,
    parameter int GAP      = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    sound_sequencer_if.slave bus
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    tone_t            cur;
    slot_t            pend;
    slot_t            pend_upd;
    slot_t            acc;
    logic [1:0]       n_lose;
    logic             p_drop;
    logic [2:0]       inc;
    logic [8:0]       drop_sum;
    logic [7:0]       drop;
    logic [7:0]       drop_nxt;

    function automatic logic [CNT_W-1:0] dur_m1(input tone_t t);
        logic [CNT_W-1:0] d;
        unique case (t)
            T_PING:  d = CNT_W'(DUR_PING - 1);
            T_PONG:  d = CNT_W'(DUR_PONG - 1);
            T_GO:    d = CNT_W'(DUR_GO - 1);
            default: d = CNT_W'(DUR_STOP - 1);
        endcase
        return d;
    endfunction

    sound_event_arbiter u_arb (
        .en      (bus.sound_en),
        .ev_ping (bus.ev_ping),
        .ev_pong (bus.ev_pong),
        .ev_go   (bus.ev_go),
        .ev_stop (bus.ev_stop),
        .acc     (acc),
        .n_lose  (n_lose)
    );

    // Pending-slot update and saturating drop count for this cycle.
    always_comb begin
        pend_upd = pend;
        p_drop   = 1'b0;
        if (acc.vld && state != ST_IDLE) begin
            if (acc.tone == T_STOP)
                p_drop = pend.vld;
            else if (!pend.vld || acc.tone >= pend.tone)
                pend_upd = acc;
            else
                p_drop = 1'b1;
        end
        inc      = {1'b0, n_lose} + {2'b0, p_drop};
        drop_sum = {1'b0, drop} + {6'b0, inc};
        drop_nxt = drop_sum[8] ? 8'hff : drop_sum[7:0];
    end

    // Sequencer FSM, duration/gap counter and pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cur   <= T_STOP;
            pend  <= '0;
            drop  <= 8'd0;
        end else begin
            drop <= drop_nxt;
            if (!bus.sound_en) begin
                state <= ST_IDLE;
                cnt   <= '0;
                pend  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (acc.vld) begin
                            state <= ST_PLAY;
                            cur   <= acc.tone;
                            cnt   <= dur_m1(acc.tone);
                        end
                    end
                    ST_PLAY, ST_GAP: begin
                        if (acc.vld && acc.tone == T_STOP) begin
                            state <= ST_PLAY;
                            cur   <= T_STOP;
                            cnt   <= dur_m1(T_STOP);
                            pend  <= '0;
                        end else if (cnt != '0) begin
                            cnt  <= cnt - 1'b1;
                            pend <= pend_upd;
                        end else if (state == ST_PLAY) begin
                            state <= ST_GAP;
                            cnt   <= CNT_W'(GAP - 1);
                            pend  <= pend_upd;
                        end else if (pend_upd.vld) begin
                            state <= ST_PLAY;
                            cur   <= pend_upd.tone;
                            cnt   <= dur_m1(pend_upd.tone);
                            pend  <= '0;
                        end else begin
                            state <= ST_IDLE;
                            pend  <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        pend  <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs decode straight from state so reset acts at once.
    always_comb begin
        bus.code_sound = (state == ST_IDLE) ? CODE_STOP
                                            : tone_code(cur);
        bus.mute       = (state != ST_PLAY);
        bus.busy       = (state != ST_IDLE);
        bus.drop_cnt   = drop;
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed table-driven bench for sound_sequencer with short
// durations, plus hand sequences for reset and saturation.
module tb_sound_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   npass = 0;
    int   ntot = 0;

    sound_sequencer_if bus ();

    sound_sequencer #(
        .CNT_W    (8),
        .DUR_PING (4),
        .DUR_PONG (3),
        .DUR_GO   (6),
        .DUR_STOP (5),
        .GAP      (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tid;
        bit         rst;
        bit         en;
        bit         pi;
        bit         po;
        bit         g;
        bit         s;
        logic [2:0] code;
        bit         mute;
        bit         busy;
        int         drop;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ev();
        bus.ev_ping = 1'b0;
        bus.ev_pong = 1'b0;
        bus.ev_go   = 1'b0;
        bus.ev_stop = 1'b0;
    endtask

    task automatic do_reset();
        clr_ev();
        bus.sound_en = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input int n, input int tid, input bit rst,
                       input bit en, input bit pi, input bit po,
                       input bit g, input bit s,
                       input logic [2:0] code, input bit mute,
                       input bit busy, input int drop);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.tid = tid; v.rst = rst && (k == 0); v.en = en;
            v.pi = pi; v.po = po; v.g = g; v.s = s;
            v.code = code; v.mute = mute; v.busy = busy;
            v.drop = drop;
            vq.push_back(v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] c,
                           input bit m, input bit b, input int d);
        chk({tag, " code"}, int'(bus.code_sound), int'(c));
        chk({tag, " mute"}, int'(bus.mute), int'(m));
        chk({tag, " busy"}, int'(bus.busy), int'(b));
        chk({tag, " drop"}, int'(bus.drop_cnt), d);
    endtask

    initial begin
        int  w;
        bit  seen;
        rst_n = 1'b0;
        bus.sound_en = 1'b1;
        clr_ev();
        #12;
        chk_out("reset_hold", 3'b000, 1, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_out("after_reset", 3'b000, 1, 0, 0);
        repeat (8) tick();

        // 1: single ping, 4 play, 2 gap, idle
        add(1, 1, 0, 1, 1, 0, 0, 0, 3'b010, 0, 1, 0);
        add(3, 1, 0, 1, 0, 0, 0, 0, 3'b010, 0, 1, 0);
        add(2, 1, 0, 1, 0, 0, 0, 0, 3'b010, 1, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        // 2: pong+go together, go wins, one drop
        add(1, 2, 1, 1, 0, 1, 1, 0, 3'b011, 0, 1, 1);
        add(5, 2, 0, 1, 0, 0, 0, 0, 3'b011, 0, 1, 1);
        add(2, 2, 0, 1, 0, 0, 0, 0, 3'b011, 1, 1, 1);
        add(1, 2, 0, 1, 0, 0, 0, 0, 3'b000, 1, 0, 1);
        // 3: pong pending, ping in gap overwrites it
        add(1, 3, 1, 1, 1, 0, 0, 0, 3'b010, 0, 1, 0);
        add(1, 3, 0, 1, 0, 1, 0, 0, 3'b010, 0, 1, 0);
        add(2, 3, 0, 1, 0, 0, 0, 0, 3'b010, 0, 1, 0);
        add(1, 3, 0, 1, 0, 0, 0, 0, 3'b010, 1, 1, 0);
        add(1, 3, 0, 1, 1, 0, 0, 0, 3'b010, 1, 1, 0);
        add(4, 3, 0, 1, 0, 0, 0, 0, 3'b010, 0, 1, 0);
        add(2, 3, 0, 1, 0, 0, 0, 0, 3'b010, 1, 1, 0);
        add(1, 3, 0, 1, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        // 4: go pending, stop preempts and drops it
        add(1, 4, 1, 1, 1, 0, 0, 0, 3'b010, 0, 1, 0);
        add(1, 4, 0, 1, 0, 0, 1, 0, 3'b010, 0, 1, 0);
        add(1, 4, 0, 1, 0, 0, 0, 1, 3'b000, 0, 1, 1);
        add(4, 4, 0, 1, 0, 0, 0, 0, 3'b000, 0, 1, 1);
        add(2, 4, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 1);
        add(1, 4, 0, 1, 0, 0, 0, 0, 3'b000, 1, 0, 1);
        // 5: sound_en low mid-tone; events ignored
        add(1, 5, 1, 1, 1, 0, 0, 0, 3'b010, 0, 1, 0);
        add(1, 5, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        add(1, 5, 0, 0, 1, 1, 0, 0, 3'b000, 1, 0, 0);
        add(1, 5, 0, 1, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        // 6: stop while stop plays restarts duration
        add(3, 6, 1, 1, 0, 0, 0, 1, 3'b000, 0, 1, 0);
        add(1, 6, 0, 1, 0, 0, 0, 1, 3'b000, 0, 1, 0);
        add(4, 6, 0, 1, 0, 0, 0, 0, 3'b000, 0, 1, 0);
        add(2, 6, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 0);
        add(1, 6, 0, 1, 0, 0, 0, 0, 3'b000, 1, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) do_reset();
            bus.sound_en = vq[i].en;
            bus.ev_ping  = vq[i].pi;
            bus.ev_pong  = vq[i].po;
            bus.ev_go    = vq[i].g;
            bus.ev_stop  = vq[i].s;
            tick();
            clr_ev();
            chk_out($sformatf("t%0d v%0d", vq[i].tid, i),
                    vq[i].code, vq[i].mute, vq[i].busy, vq[i].drop);
        end

        // async reset in the middle of a go tone
        do_reset();
        bus.ev_go = 1'b1;
        tick();
        clr_ev();
        tick();
        chk("go_mid code", int'(bus.code_sound), 3);
        chk("go_mid mute", int'(bus.mute), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 3'b000, 1, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ev_ping = 1'b1;
        tick();
        clr_ev();
        chk_out("post_rst ping", 3'b010, 0, 1, 0);

        // drop counter saturation
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            bus.ev_ping = 1'b1;
            bus.ev_pong = 1'b1;
            tick();
            if (k == 100)
                chk("drop_100", int'(bus.drop_cnt), 100);
        end
        clr_ev();
        chk("drop_sat", int'(bus.drop_cnt), 255);
        seen = 1'b0;
        w = 0;
        while (!seen && w < 20) begin
            if (!bus.mute) seen = 1'b1;
            else tick();
            w++;
        end
        chk("wait_play", int'(seen), 1);
        bus.sound_en = 1'b0;
        tick();
        chk_out("en_off", 3'b000, 1, 0, 255);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 24: width of the duration/gap down-counter.
REQ-002 The block SHALL have parameters DUR_PING, DUR_PONG, DUR_GO, DUR_STOP (defaults 1_250_000, 1_250_000, 5_000_000, 10_000_000): tone length in clk cycles, each in 1..2^CNT_W-1.
REQ-003 The block SHALL have parameter GAP, default 250_000: mandatory silent cycles between consecutive tones, in 1..2^CNT_W-1.
REQ-004 clk  in  1  system clock; all logic is clocked on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 sound_en  in  1  global enable; 0 = ignore events and silence output.
REQ-007 ev_ping, ev_pong, ev_go, ev_stop  in  1 each  single-cycle game event pulses.
REQ-008 code_sound  out  3  tone code to sound_controller: ping 3'b010, pong 3'b001, go 3'b011, stop 3'b000.
REQ-009 mute  out  1  1 = silence the sound_controller output.
REQ-010 busy  out  1  1 when state is not IDLE.
REQ-011 drop_cnt  out  8  saturating count of discarded events.

Function
REQ-012 The FSM SHALL have states IDLE, PLAY and GAP.
REQ-013 Event priority SHALL be stop > go > ping > pong; among simultaneous pulses only the highest is accepted and each other asserted pulse increments drop_cnt.
REQ-014 In IDLE with sound_en=1, an event accepted in cycle N SHALL produce code_sound = its code and mute=0 from cycle N+1, with the state in PLAY.
REQ-015 On entering PLAY, the counter SHALL load DUR_x-1 and decrement each cycle; the cycle in which it reads 0 is the last PLAY cycle, giving exactly DUR_x cycles with mute=0.
REQ-016 After the last PLAY cycle, the state SHALL be GAP for exactly GAP cycles, with mute=1 and code_sound held.
REQ-017 A one-entry pending slot SHALL capture non-stop events accepted in PLAY or GAP; a new event overwrites the slot only if its priority is >= the slot's, otherwise it is dropped (drop_cnt++).
REQ-018 At the end of GAP, the FSM SHALL enter PLAY with the pending tone (slot cleared) if the slot is valid, otherwise IDLE.
REQ-019 ev_stop accepted in PLAY or GAP SHALL preempt: the pending slot is cleared (a valid entry counts as dropped), and the FSM enters PLAY with stop from the next cycle, with no gap.
REQ-020 ev_stop while stop is already playing SHALL restart the stop duration.
REQ-021 An event in the same cycle as the last PLAY or last GAP cycle SHALL be treated as arriving in that state (pending rules apply).
REQ-022 In IDLE, mute SHALL be 1 and code_sound SHALL be 3'b000.
REQ-023 sound_en=0 SHALL force, on the next cycle, state IDLE, pending slot empty and mute=1; events seen while sound_en=0 are ignored and not counted.
REQ-024 drop_cnt SHALL saturate at 255 and never wrap.

Reset
REQ-025 Asserting rst_n low SHALL immediately set state IDLE, counter 0, pending slot empty, code_sound 3'b000, mute 1, busy 0, drop_cnt 0, including mid-tone.
REQ-026 The first event SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-027 Tone codes, the state encoding and a priority-encode function SHALL live in a shared package sound_pkg, used by both sound_sequencer and sound_controller.
REQ-028 One sub-module, sound_event_arbiter (combinational priority encode plus drop-count increments), is natural; the FSM, counter and pending slot stay in sound_sequencer.

Verification (bench parameters: DUR_PING=4, DUR_PONG=3, DUR_GO=6, DUR_STOP=5, GAP=2)
REQ-029 Reset, then ev_ping at cycle 10 -> code_sound=010 with mute=0 in cycles 11-14, mute=1 in cycles 15-16, IDLE and busy=0 from cycle 17.
REQ-030 ev_pong and ev_go in the same cycle while IDLE -> go plays for 6 cycles, drop_cnt=1.
REQ-031 ev_pong during ping PLAY, then ev_ping before the gap ends -> after the gap, ping plays (ping overwrites pong), drop_cnt=0.
REQ-032 ev_go pending, then ev_stop during ping PLAY -> stop (000, mute=0) on the next cycle for 5 cycles, then a 2-cycle gap, then IDLE; drop_cnt=1.
REQ-033 rst_n low for 1 cycle mid-go -> mute=1, code_sound=000 and busy=0 asynchronously; the next event plays normally.
REQ-034 300 simultaneous ping+pong pulses while IDLE or PLAY -> drop_cnt stops at 255; sound_en=0 mid-tone -> mute=1 and IDLE on the next cycle.
